// File: rtl/seq_mul_257.sv
// seq_mul_257: sequential W x W unsigned multiplier producing the full 2W-bit product.
// Operand B is consumed one LIMB-bit slice per cycle, so a single W x LIMB multiplier
// and one 2W-bit adder do all the work. The done pulse can drive a downstream start directly.
//
// state  | meaning
// S_IDLE | waiting for start; done/busy from the previous op drop on the first edge here
// S_MUL  | one limb of b_q accumulated into acc per edge
// S_FIN  | acc copied to product, done raised for one cycle

module seq_mul_257 #(
    parameter int W    = 257,
    parameter int LIMB = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int N    = (W + LIMB - 1) / LIMB;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int BW   = N * LIMB;
    localparam int SHW  = $clog2(BW) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2*W-1:0]  product_q, product_d;

    logic [SHW-1:0]    shamt;
    logic [LIMB-1:0]   limb;
    logic [W+LIMB-1:0] pp;
    logic [2*W-1:0]    term;

    // Partial product for the current limb, aligned to its weight. The shifted term is
    // truncated to 2W bits, which never drops a set bit since every partial sum is <= a*b.
    always_comb begin
        shamt = SHW'(idx_q) * SHW'(LIMB);
        limb  = b_q[shamt +: LIMB];
        pp    = (W+LIMB)'(a_q) * (W+LIMB)'(limb);
        term  = (2*W)'(pp) << shamt;
    end

    // Next-state and next-output logic; all outputs come straight from flops.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d     = a;
                    b_d     = BW'(b);
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = acc_q + term;
                if (idx_q == IDXW'(N - 1)) begin
                    idx_d   = '0;
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_FIN: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mul_257.sv
// Directed bench for seq_mul_257: scoreboard of expected products, immediate-assertion checks.
module tb_seq_mul_257;

    localparam int W = 257;
    localparam int LAT = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] sb[$];

    seq_mul_257 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx, yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
        return r[W-1:0];
    endfunction

    // Called #1 after an edge; the next edge is E0. Returns #1 after E0.
    task automatic issue(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib);
        a = ia;
        b = ib;
        start = 1'b1;
        sb.push_back(mul_ref(ia, ib));
        step();
        start = 1'b0;
        chk({tag, "_busy_e0"}, 514'(busy), 514'(1'b1));
    endtask

    // Called #1 after E0. Optional extra start pulses sampled at edges p1/p2.
    // Returns #1 after the edge that raised done, with busy sample count.
    task automatic wait_done(input string tag, input int p1, input int p2, output int busy_cnt);
        int n;
        logic hold_ok;
        logic [2*W-1:0] prev;
        logic [2*W-1:0] exp;
        n = 0;
        hold_ok = 1'b1;
        prev = product;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 20) begin
            if (n + 1 == p1 || n + 1 == p2) begin
                start = 1'b1;
                a = ~a;
                b = b ^ 257'h5a5a;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
            if (busy) busy_cnt++;
            if (!done && product !== prev) hold_ok = 1'b0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 514'(n), 514'(LAT));
        chk({tag, "_hold"}, 514'(hold_ok), 514'(1'b1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 514'(0), 514'(1));
        end else begin
            exp = sb.pop_front();
            if (done) chk({tag, "_product"}, product, exp);
        end
    endtask

    initial begin
        int bc;
        logic [2*W-1:0] ones_sq;
        logic           extra;

        #12;
        chk("reset_done", 514'(done), 514'(0));
        chk("reset_busy", 514'(busy), 514'(0));
        chk("reset_product", product, '0);
        rst_n = 1'b1;
        step();

        // 1 x 1: latency and busy window
        issue("one", 257'd1, 257'd1);
        wait_done("one", -1, -1, bc);
        chk("one_busy_cycles", 514'(bc), 514'(7));
        chk("one_busy_in_done", 514'(busy), 514'(1));
        step();
        chk("one_busy_after", 514'(busy), 514'(0));
        chk("one_done_after", 514'(done), 514'(0));

        // all-ones operands
        ones_sq = '0 - (514'd1 << 258) + 514'd1;
        issue("ones", '1, '1);
        wait_done("ones", -1, -1, bc);
        chk("ones_formula", product, ones_sq);
        step();

        // zero products, previous nonzero product held until done
        issue("zero_b", (257'd1 << 255) - 257'd19, '0);
        wait_done("zero_b", -1, -1, bc);
        step();
        chk("zero_b_held", product, '0);
        issue("dummy", 257'd9, 257'd9);
        wait_done("dummy", -1, -1, bc);
        issue("zero_a", '0, (257'd1 << 256) + 257'd5);
        wait_done("zero_a", -1, -1, bc);
        step();

        // extra starts on E2 and on the FIN edge are ignored
        issue("ign", (257'd1 << 200) + 257'd3, (257'd1 << 128) + 257'd7);
        wait_done("ign", 2, 6, bc);
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) extra = 1'b1;
        end
        chk("ign_no_extra_done", 514'(extra), 514'(0));
        chk("ign_idle_busy", 514'(busy), 514'(0));

        // async reset mid-operation
        issue("rst", 257'd11, 257'd13);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_done", 514'(done), 514'(0));
        chk("rst_busy", 514'(busy), 514'(0));
        chk("rst_product", product, '0);
        void'(sb.pop_back());
        #10;
        rst_n = 1'b1;
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) extra = 1'b1;
        end
        chk("rst_no_done", 514'(extra), 514'(0));
        issue("post_rst", 257'd3, 257'd5);
        wait_done("post_rst", -1, -1, bc);
        chk("post_rst_15", product, 514'd15);

        // back-to-back random operations
        for (int k = 0; k < 20; k++) begin
            issue("b2b", rand_op(), rand_op());
            wait_done("b2b", -1, -1, bc);
        end
        extra = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) extra = 1'b1;
        end
        chk("b2b_no_extra_done", 514'(extra), 514'(0));
        chk("sb_empty", 514'(sb.size()), 514'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
